payload_frame_buffer: RTL and testbench
=======================================

# payload_frame_buffer

Store-and-forward packet buffer directly downstream of `top_payload_generator`. It accepts the generator's 256-bit AXI-Stream order payloads and holds each packet until its `tlast` beat has arrived. It then releases the complete packet to the Ethernet/UDP framer with a byte-length and checksum descriptor, so the framer never stalls mid-packet. Oversize packets are dropped whole.

## Interface
Parameters:
- `DEPTH`, default 16: data buffer depth in 256-bit beats; power of 2, 2..1024.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `resetn`, in, 1: reset, asynchronous, active-low.
- `s_tvalid`, in, 1: upstream beat valid.
- `s_tready`, out, 1: buffer can accept a beat.
- `s_tdata`, in, 256: payload beat; byte 0 is `[7:0]`.
- `s_tkeep`, in, 32: byte enables.
- `s_tlast`, in, 1: last beat of the packet.
- `m_tvalid`, out, 1: output beat valid.
- `m_tready`, in, 1: downstream accepts the beat.
- `m_tdata`, out, 256: stored beat.
- `m_tkeep`, out, 32: stored byte enables.
- `m_tlast`, out, 1: stored last flag.
- `m_len`, out, 16: byte count of the current output packet; stable for the whole packet.
- `m_chksum`, out, 8: byte checksum of the current output packet; see Configuration.
- `drop_cnt`, out, 16: number of dropped oversize packets; saturates at `16'hFFFF`.

## Operation
- Data RAM holds `DEPTH` entries of {tdata, tkeep, tlast}. Pointers `wr_ptr`, `commit_ptr` and `rd_ptr` are each `$clog2(DEPTH)+1` bits wide, with wrap bit.
- Write side FSM, states IDLE, RECV, DROP:
  - IDLE → RECV on the first accepted beat of a packet. A single-beat packet (`tlast` on the first beat) commits immediately and the FSM stays in IDLE.
  - In RECV, each accepted beat is written at `wr_ptr`. The accumulators update as `len += popcount(tkeep)` and `sum += each kept byte`, mod 256.
  - On the `tlast` beat: `commit_ptr ← wr_ptr+1`, push the descriptor {len, sum} into the descriptor FIFO, clear the accumulators, and return to IDLE.
- Full handling (RAM full means `wr_ptr − rd_ptr == DEPTH`):
  - If RAM is full and the descriptor FIFO is non-empty, deassert `s_tready` (backpressure).
  - If RAM is full and the descriptor FIFO is empty, the current packet exceeds `DEPTH`. Enter DROP: `s_tready` = 1 and beats are discarded.
  - On the `tlast` beat in DROP: `wr_ptr ← commit_ptr`, `drop_cnt++`, return to IDLE.
- Read side:
  - `m_tvalid` = descriptor FIFO non-empty. `m_len` and `m_chksum` come from the FIFO head.
  - Each handshake increments `rd_ptr`. The handshake on an `m_tlast` beat also pops the descriptor.
- Descriptor FIFO depth is `DEPTH`, so it can never overflow.

## Timing
- Reset values: `s_tready`=1, `m_tvalid`=0, `m_tdata`/`m_tkeep`/`m_tlast`/`m_len`/`m_chksum`=0, `drop_cnt`=0, FSM=IDLE, all pointers 0.
- Latency: `m_tvalid` rises in the cycle after the `tlast` input handshake. Output then streams at 1 beat/cycle while `m_tready`=1.
- `m_*` signals are held stable while `m_tvalid`=1 and `m_tready`=0.
- Simultaneous read and write in the same cycle are both allowed. A read that frees the last entry re-enables `s_tready` in the next cycle; `s_tready` is registered.
- Reset mid-packet discards all stored and partial data. There are no output glitches after deassertion.
- Width rule: the maximum length is 32·1024 = 32768, which fits in 16 bits.

## Configuration
- `PAYLOAD_CHKSUM_EN` defined: checksum accumulator is built and the descriptor carries the 8-bit sum; `m_chksum` is valid.
- `PAYLOAD_CHKSUM_EN` undefined: accumulator and descriptor field are removed; `m_chksum` is tied to `8'h00`.

## Structure
- The shared package `payload_pkg` holds:
  - `AXIS_DATA_W`=256 and `AXIS_KEEP_W`=32;
  - the `payload_desc_t` struct {len[15:0], chksum[7:0]};
  - the write-FSM state enum.
- One sub-module, `payload_desc_fifo`: a synchronous FIFO of `payload_desc_t` with `DEPTH` entries and full/empty flags.

## Test plan
- One packet of 3 beats with tkeep `FFFFFFFF`, `FFFFFFFF`, `0000FFFF` and all bytes `8'h01` → `m_tvalid` in the cycle after `tlast`; `m_len`=80, `m_chksum`=`8'h50`; 3 beats out unchanged.
- Single-beat packet with tkeep `0000000F` and bytes 01,02,03,04 → `m_len`=4, `m_chksum`=`8'h0A`, `m_tlast`=1 on the only beat.
- `DEPTH`=4; send 4 one-beat packets with `m_tready`=0 → `s_tready` drops after the 4th. Raise `m_tready` → all 4 packets emerge in order with correct descriptors.
- `DEPTH`=4; send a 6-beat packet followed by a 1-beat packet → `drop_cnt`=1; only the 1-beat packet appears on the output.
- Toggle `m_tready` randomly during a 3-beat packet → data and descriptor held stable during stalls; no beats lost or duplicated.
- Assert `resetn`=0 mid-packet, then release → all outputs at reset values; the next packet passes through normally.

Source files
------------

// File: rtl/payload_pkg.sv
// Shared types for the payload frame buffer.
// PAYLOAD_CHKSUM_EN adds the 8-bit byte checksum to the descriptor.
package payload_pkg;

  localparam int AXIS_DATA_W = 256;
  localparam int AXIS_KEEP_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP
  } wr_state_e;

`ifdef PAYLOAD_CHKSUM_EN
  typedef struct packed {
    logic [15:0] len;
    logic [7:0]  chksum;
  } payload_desc_t;
`else
  typedef struct packed {
    logic [15:0] len;
  } payload_desc_t;
`endif

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_KEEP_W-1:0] keep;
    logic                   last;
  } payload_beat_t;

  function automatic logic [5:0] keep_count(
    input logic [AXIS_KEEP_W-1:0] keep
  );
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < AXIS_KEEP_W; i++)
      n += 6'(keep[i]);
    return n;
  endfunction

  function automatic logic [7:0] byte_sum(
    input logic [AXIS_DATA_W-1:0] data,
    input logic [AXIS_KEEP_W-1:0] keep
  );
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < AXIS_KEEP_W; i++)
      if (keep[i]) s += data[8*i +: 8];
    return s;
  endfunction

endpackage

// File: rtl/payload_desc_fifo.sv
// Synchronous descriptor FIFO, one entry per committed packet.
// Head entry is visible combinationally on dout.
module payload_desc_fifo
  import payload_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  payload_desc_t din,
  input  logic          pop,
  output payload_desc_t dout,
  output logic          full,
  output logic          empty,
  output logic          empty_nxt
);

  localparam int AW = $clog2(DEPTH);

  payload_desc_t mem [DEPTH];

  logic [AW:0] wp;
  logic [AW:0] rp;
  logic [AW:0] wp_n;
  logic [AW:0] rp_n;
  logic        do_push;
  logic        do_pop;

  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = (wp == rp);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign wp_n = wp + {{AW{1'b0}}, do_push};
  assign rp_n = rp + {{AW{1'b0}}, do_pop};

  assign empty_nxt = (wp_n == rp_n);
  assign dout      = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp_n;
      rp <= rp_n;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/payload_frame_buffer.sv
// Store-and-forward AXI-Stream packet buffer with length descriptor.
// PAYLOAD_CHKSUM_EN builds the byte checksum; otherwise m_chksum is 0.
module payload_frame_buffer
  import payload_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [AXIS_DATA_W-1:0] s_tdata,
  input  logic [AXIS_KEEP_W-1:0] s_tkeep,
  input  logic                   s_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [AXIS_DATA_W-1:0] m_tdata,
  output logic [AXIS_KEEP_W-1:0] m_tkeep,
  output logic                   m_tlast,
  output logic [15:0]            m_len,
  output logic [7:0]             m_chksum,
  output logic [15:0]            drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  payload_beat_t mem [DEPTH];
  payload_beat_t rd_beat;

  wr_state_e     state;
  wr_state_e     state_n;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   wr_ptr_n;
  logic [AW:0]   commit_ptr;
  logic [AW:0]   commit_ptr_n;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   rd_ptr_n;
  logic [15:0]   len_acc;
  logic [15:0]   len_beat;
  logic [15:0]   drop_q;
  logic [15:0]   drop_n;
  logic          rdy_q;
  logic          rdy_n;

  logic          s_hs;
  logic          m_hs;
  logic          full;
  logic          wr_en;
  logic          push_req;
  logic          acc_clr;
  logic          acc_load;

  payload_desc_t desc_in;
  payload_desc_t desc_head;
  logic          desc_full;
  logic          desc_empty;
  logic          desc_empty_nxt;

  assign s_hs = s_tvalid && rdy_q;
  assign m_hs = m_tvalid && m_tready;
  assign full = (wr_ptr - rd_ptr) == FULL_LVL;

  assign len_beat = len_acc +
                    {10'b0, keep_count(s_tkeep)};

  // The accumulators include the current beat so that
  // a packet ending on this beat gets a complete descriptor.
  always_comb begin
    state_n      = state;
    wr_ptr_n     = wr_ptr;
    commit_ptr_n = commit_ptr;
    drop_n       = drop_q;
    wr_en        = 1'b0;
    push_req     = 1'b0;
    acc_clr      = 1'b0;
    acc_load     = 1'b0;
    unique case (state)
      IDLE, RECV: begin
        if (s_hs && full) begin
          acc_clr = 1'b1;
          if (s_tlast) begin
            wr_ptr_n = commit_ptr;
            drop_n   = (drop_q == 16'hFFFF) ?
                       drop_q : drop_q + 16'd1;
            state_n  = IDLE;
          end else begin
            state_n = DROP;
          end
        end else if (s_hs) begin
          wr_en    = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
          if (s_tlast) begin
            commit_ptr_n = wr_ptr + 1'b1;
            push_req     = 1'b1;
            acc_clr      = 1'b1;
            state_n      = IDLE;
          end else begin
            acc_load = 1'b1;
            state_n  = RECV;
          end
        end
      end
      DROP: begin
        if (s_hs && s_tlast) begin
          wr_ptr_n = commit_ptr;
          drop_n   = (drop_q == 16'hFFFF) ?
                     drop_q : drop_q + 16'd1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, m_hs};

  // Backpressure only while committed packets still occupy
  // a full RAM; a full RAM with nothing committed is oversize.
  assign rdy_n = (state_n == DROP) ||
                 !(((wr_ptr_n - rd_ptr_n) == FULL_LVL) &&
                   !desc_empty_nxt);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      len_acc    <= '0;
      drop_q     <= '0;
      rdy_q      <= 1'b1;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_ptr_n;
      rd_ptr     <= rd_ptr_n;
      drop_q     <= drop_n;
      rdy_q      <= rdy_n;
      if (acc_clr)
        len_acc <= '0;
      else if (acc_load)
        len_acc <= len_beat;
    end
  end

`ifdef PAYLOAD_CHKSUM_EN
  logic [7:0] sum_acc;
  logic [7:0] sum_beat;

  assign sum_beat = sum_acc + byte_sum(s_tdata, s_tkeep);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      sum_acc <= '0;
    else if (acc_clr)
      sum_acc <= '0;
    else if (acc_load)
      sum_acc <= sum_beat;
  end

  assign desc_in.len    = len_beat;
  assign desc_in.chksum = sum_beat;
`else
  assign desc_in.len = len_beat;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]].data <= s_tdata;
      mem[wr_ptr[AW-1:0]].keep <= s_tkeep;
      mem[wr_ptr[AW-1:0]].last <= s_tlast;
    end
  end

  payload_desc_fifo #(
    .DEPTH(DEPTH)
  ) u_desc_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (push_req && !desc_full),
    .din      (desc_in),
    .pop      (m_hs && rd_beat.last),
    .dout     (desc_head),
    .full     (desc_full),
    .empty    (desc_empty),
    .empty_nxt(desc_empty_nxt)
  );

  assign rd_beat  = mem[rd_ptr[AW-1:0]];
  assign s_tready = rdy_q;
  assign drop_cnt = drop_q;

  // Outputs are forced to zero when idle so stale RAM and
  // FIFO contents never appear after reset.
  assign m_tvalid = !desc_empty;
  assign m_tdata  = m_tvalid ? rd_beat.data : '0;
  assign m_tkeep  = m_tvalid ? rd_beat.keep : '0;
  assign m_tlast  = m_tvalid && rd_beat.last;
  assign m_len    = m_tvalid ? desc_head.len : '0;
`ifdef PAYLOAD_CHKSUM_EN
  assign m_chksum = m_tvalid ? desc_head.chksum : '0;
`else
  assign m_chksum = 8'h00;
`endif

endmodule

// File: tb/tb_payload_frame_buffer.sv
// Self-checking bench for payload_frame_buffer (DEPTH=4).
// Scoreboard of expected output beats plus table of 1-beat packets.
module tb_payload_frame_buffer;

  logic         clk = 1'b0;
  logic         resetn;
  logic         s_tvalid;
  logic         s_tready;
  logic [255:0] s_tdata;
  logic [31:0]  s_tkeep;
  logic         s_tlast;
  logic         m_tvalid;
  logic         m_tready;
  logic [255:0] m_tdata;
  logic [31:0]  m_tkeep;
  logic         m_tlast;
  logic [15:0]  m_len;
  logic [7:0]   m_chksum;
  logic [15:0]  drop_cnt;

  always #5 clk = ~clk;

  payload_frame_buffer #(
    .DEPTH(4)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tdata (s_tdata),
    .s_tkeep (s_tkeep),
    .s_tlast (s_tlast),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tdata (m_tdata),
    .m_tkeep (m_tkeep),
    .m_tlast (m_tlast),
    .m_len   (m_len),
    .m_chksum(m_chksum),
    .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
    logic [15:0]  len;
    logic [7:0]   sum;
  } exp_t;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic [15:0]  len;
    logic [7:0]   sum;
  } vec_t;

  exp_t q[$];
  vec_t tbl[5];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] xs(input logic [7:0] s);
`ifdef PAYLOAD_CHKSUM_EN
    return s;
`else
    return s & 8'h00;
`endif
  endfunction

  task automatic chk(input string name,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [255:0] d,
                          input logic [31:0] k,
                          input logic l,
                          input logic [15:0] n,
                          input logic [7:0] s);
    exp_t e;
    e.data = d;
    e.keep = k;
    e.last = l;
    e.len  = n;
    e.sum  = xs(s);
    q.push_back(e);
  endtask

  // Entered just after a rising edge; returns just after
  // the rising edge on which the beat was accepted.
  task automatic send_beat(input logic [255:0] d,
                           input logic [31:0] k,
                           input logic l);
    int n;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    n = 0;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL s_tready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending expected 0",
               name, q.size());
    end
    #1;
    @(negedge clk);
    chk({name, "_idle_valid"}, 256'(m_tvalid), 256'(0));
    tick();
  endtask

  task automatic check_reset(input string name);
    chk({name, "_s_tready"}, 256'(s_tready), 256'(1));
    chk({name, "_m_tvalid"}, 256'(m_tvalid), 256'(0));
    chk({name, "_m_tdata"}, m_tdata, 256'(0));
    chk({name, "_m_tkeep"}, 256'(m_tkeep), 256'(0));
    chk({name, "_m_tlast"}, 256'(m_tlast), 256'(0));
    chk({name, "_m_len"}, 256'(m_len), 256'(0));
    chk({name, "_m_chksum"}, 256'(m_chksum), 256'(0));
    chk({name, "_drop_cnt"}, 256'(drop_cnt), 256'(0));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resetn && m_tvalid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %h expected none",
                 m_tdata);
      end else begin
        e = q[0];
        chk("out_data", m_tdata, e.data);
        chk("out_keep", 256'(m_tkeep), 256'(e.keep));
        chk("out_last", 256'(m_tlast), 256'(e.last));
        chk("out_len", 256'(m_len), 256'(e.len));
        chk("out_chksum", 256'(m_chksum), 256'(e.sum));
        if (m_tready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;

    tbl[0] = '{256'h04030201, 32'h0000000F,
               16'd4, 8'h0A};
    tbl[1] = '{{32{8'h01}}, 32'hFFFFFFFF,
               16'd32, 8'h20};
    tbl[2] = '{{{31{8'h33}}, 8'hFF}, 32'h00000001,
               16'd1, 8'hFF};
    tbl[3] = '{{8'h20, {30{8'hAA}}, 8'h10}, 32'h80000001,
               16'd2, 8'h30};
    tbl[4] = '{{32{8'h11}}, 32'hFFFF0000,
               16'd16, 8'h10};

    resetn   = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    tick();
    resetn = 1'b1;
    tick();

    // 3-beat packet with explicit latency checks
    push_exp({32{8'h01}}, 32'hFFFFFFFF, 1'b0, 16'd80, 8'h50);
    push_exp({32{8'h01}}, 32'hFFFFFFFF, 1'b0, 16'd80, 8'h50);
    push_exp({32{8'h01}}, 32'h0000FFFF, 1'b1, 16'd80, 8'h50);
    send_beat({32{8'h01}}, 32'hFFFFFFFF, 1'b0);
    send_beat({32{8'h01}}, 32'hFFFFFFFF, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = {32{8'h01}};
    s_tkeep  = 32'h0000FFFF;
    s_tlast  = 1'b1;
    @(negedge clk);
    chk("p3_early_valid", 256'(m_tvalid), 256'(0));
    chk("p3_ready", 256'(s_tready), 256'(1));
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    @(negedge clk);
    chk("p3_latency", 256'(m_tvalid), 256'(1));
    chk("p3_len", 256'(m_len), 256'(80));
    tick();
    drain("p3");

    // table of single-beat packets
    for (int i = 0; i < 5; i++) begin
      push_exp(tbl[i].data, tbl[i].keep, 1'b1,
               tbl[i].len, tbl[i].sum);
      send_beat(tbl[i].data, tbl[i].keep, 1'b1);
      @(negedge clk);
      chk("tbl_latency", 256'(m_tvalid), 256'(1));
      tick();
    end
    drain("tbl");

    // fill RAM with four committed packets, then release
    m_tready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      b = 8'(k);
      push_exp({224'h0, b, b, b, b}, 32'h0000000F, 1'b1,
               16'd4, 8'(4 * k));
      send_beat({224'h0, b, b, b, b}, 32'h0000000F, 1'b1);
      @(negedge clk);
      chk("full_ready", 256'(s_tready),
          256'((k < 4) ? 1 : 0));
      tick();
    end
    repeat (3) tick();
    @(negedge clk);
    chk("full_hold_ready", 256'(s_tready), 256'(0));
    tick();
    m_tready = 1'b1;
    drain("full");
    @(negedge clk);
    chk("full_ready_back", 256'(s_tready), 256'(1));
    tick();

    // oversize packet dropped, next packet passes
    chk("drop_before", 256'(drop_cnt), 256'(0));
    for (int i = 0; i < 6; i++)
      send_beat({32{8'hEE}}, 32'hFFFFFFFF, (i == 5));
    push_exp(256'h030201, 32'h00000007, 1'b1, 16'd3, 8'h06);
    send_beat(256'h030201, 32'h00000007, 1'b1);
    drain("drop");
    chk("drop_after", 256'(drop_cnt), 256'(1));

    // random output stalls across a 3-beat packet
    push_exp({32{8'h01}}, 32'hFFFFFFFF, 1'b0, 16'd72, 8'h78);
    push_exp({32{8'h02}}, 32'hFFFFFFFF, 1'b0, 16'd72, 8'h78);
    push_exp({32{8'h03}}, 32'h000000FF, 1'b1, 16'd72, 8'h78);
    fork
      begin
        send_beat({32{8'h01}}, 32'hFFFFFFFF, 1'b0);
        send_beat({32{8'h02}}, 32'hFFFFFFFF, 1'b0);
        send_beat({32{8'h03}}, 32'h000000FF, 1'b1);
      end
      begin
        repeat (30) begin
          m_tready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    m_tready = 1'b1;
    drain("stall");

    // reset in the middle of a packet
    send_beat({32{8'h77}}, 32'hFFFFFFFF, 1'b0);
    send_beat({32{8'h77}}, 32'hFFFFFFFF, 1'b0);
    resetn = 1'b0;
    @(negedge clk);
    check_reset("mid");
    tick();
    resetn = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_valid", 256'(m_tvalid), 256'(0));
    tick();
    push_exp(256'h0605, 32'h00000003, 1'b1, 16'd2, 8'h0B);
    send_beat(256'h0605, 32'h00000003, 1'b1);
    drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
